// File: rtl/dm_access_pkg.sv
// Shared encodings for the DM load/store controller: funct3 codes, FSM states
// and the funct3 legality check used at request accept.
package dm_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic store_ok;
    store_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (we) return store_ok;
    return store_ok || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Core-side request/response bundle. master = MEM stage, slave = controller.
// Responses are single-cycle pulses with no backpressure.
interface dm_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering between a 32-bit DM word and a sub-word access.
// Purely combinational; no latency, no flow control.
module dm_lane_align
  import dm_access_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_ext_o,
  output logic [31:0] merged_word_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

    case (funct3_i)
      F3_B:    load_ext_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_ext_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_ext_o = {24'h0, byte_sel};
      F3_HU:   load_ext_o = {16'h0, half_sel};
      default: load_ext_o = rd_word_i;
    endcase

    // Stores only ever carry funct3 000/001/010, so the low two bits pick the size.
    merged_word_o = rd_word_i;
    case (funct3_i[1:0])
      2'b00: merged_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      2'b01: begin
        if (addr_lo_i[1]) merged_word_o[31:16] = wdata_i[15:0];
        else              merged_word_o[15:0]  = wdata_i[15:0];
      end
      default: merged_word_o = wdata_i;
    endcase

    case (funct3_i[1:0])
      2'b01:   misalign_o = addr_lo_i[0];
      2'b10:   misalign_o = |addr_lo_i;
      default: misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// RISC-V load/store controller for a word-only DM; sub-word stores are read-modify-write.
// Accept->resp: error 1, load/SW 2, SB/SH 3 cycles; req_ready low while busy, resp not backpressured.
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  dm_access_ctrl_if.slave     bus,
  output logic                DM_enable,
  output logic                DM_write,
  output logic [ADDR_W-1:0]   DM_address,
  output logic [DATA_W-1:0]   DM_in,
  input  logic [DATA_W-1:0]   DM_out
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                err_q, err_d;

  logic [2:0]          lane_f3;
  logic [1:0]          lane_lo;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   merged_word;
  logic                misalign;
  logic                req_err;
  logic                dm_active;

  // In IDLE the aligner checks the incoming request; afterwards it serves the latched one.
  assign lane_f3 = (state_q == S_IDLE) ? bus.req_funct3   : f3_q;
  assign lane_lo = (state_q == S_IDLE) ? bus.req_addr[1:0] : addr_q[1:0];

  dm_lane_align u_lane_align (
    .funct3_i      (lane_f3),
    .addr_lo_i     (lane_lo),
    .rd_word_i     (word_q),
    .wdata_i       (wdata_q),
    .load_ext_o    (load_ext),
    .merged_word_o (merged_word),
    .misalign_o    (misalign)
  );

  assign req_err = misalign || (|bus.req_addr[31:ADDR_W+2]) ||
                   !f3_legal(bus.req_we, bus.req_funct3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr[ADDR_W+1:0];
          wdata_d = bus.req_wdata;
          word_d  = '0;
          err_d   = req_err;
          if (req_err)                                    state_d = S_RESP;
          else if (bus.req_we && bus.req_funct3 == F3_W)  state_d = S_WR;
          else                                            state_d = S_RD;
        end
      end
      S_RD: begin
        word_d  = DM_out;
        state_d = we_q ? S_WR : S_RESP;
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign dm_active = (state_q == S_RD) || (state_q == S_WR);

  // Reset gating keeps the strobes inactive even if the state register is mid-access.
  assign DM_enable  = !(rst_n && dm_active);
  assign DM_write   = !(rst_n && (state_q == S_WR));
  assign DM_address = dm_active ? addr_q[ADDR_W+1:2] : '0;
  assign DM_in      = (state_q == S_WR) ? merged_word : '0;

  assign bus.req_ready  = rst_n && (state_q == S_IDLE);
  assign bus.resp_valid = rst_n && (state_q == S_RESP);
  assign bus.resp_err   = bus.resp_valid && err_q;
  assign bus.resp_rdata = (bus.resp_valid && !err_q && !we_q) ? load_ext : '0;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl with a behavioural word memory.
module tb_dm_access_ctrl;
  import dm_access_pkg::*;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              DM_enable, DM_write;
  logic [ADDR_W-1:0] DM_address;
  logic [31:0]       DM_in, DM_out;

  dm_access_ctrl_if bus();

  dm_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .DM_enable  (DM_enable),
    .DM_write   (DM_write),
    .DM_address (DM_address),
    .DM_in      (DM_in),
    .DM_out     (DM_out)
  );

  initial forever #5 clk = ~clk;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [31:0]       bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (!DM_enable && !DM_write) mem[DM_address] <= DM_in;
  end
  assign DM_out = mem[DM_address];

  int n_chk = 0, n_fail = 0, cyc = 0, next_id = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          c0;
    int          id;
  } exp_t;
  exp_t exp_q[$];

  // Response monitor: every resp pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: resp_valid=1 rdata=%h err=%b, expected no response",
                 bus.resp_rdata, bus.resp_err);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("req%0d_rdata", e.id), bus.resp_rdata, e.rdata);
        chk($sformatf("req%0d_err", e.id), 32'(bus.resp_err), 32'(e.err));
        chk($sformatf("req%0d_latency", e.id), 32'(cyc - e.c0), 32'(e.lat));
        chk($sformatf("req%0d_ready_busy", e.id), 32'(bus.req_ready), 32'd0);
      end
    end
  end

  int                dm_acc_cnt = 0, dm_wr_cnt = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [31:0]       last_wr_data = '0;

  always @(negedge clk) begin
    if (DM_enable === 1'b0) dm_acc_cnt++;
    if (DM_enable === 1'b0 && DM_write === 1'b1) last_rd_addr = DM_address;
    if (DM_write === 1'b0) begin
      dm_wr_cnt++;
      last_wr_addr = DM_address;
      last_wr_data = DM_in;
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd, input logic err,
                       input int lat, input bit hold, input bit expect_resp);
    int g = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    while (bus.req_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (bus.req_ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, expected 1", bus.req_ready, g);
      bus.req_valid = 1'b0;
      return;
    end
    if (expect_resp) exp_q.push_back('{rd, err, lat, cyc, next_id});
    next_id++;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.req_valid  = 1'b0;
      bus.req_we     = ~we;
      bus.req_funct3 = 3'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
    end
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (exp_q.size() != 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d responses outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  int acc0, wr0;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    @(negedge clk);
    chk("in_reset_ready", 32'(bus.req_ready), 32'd0);
    chk("in_reset_dm_en", 32'(DM_enable), 32'd1);
    chk("in_reset_dm_wr", 32'(DM_write), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_dm_en", 32'(DM_enable), 32'd1);
    chk("rst_dm_wr", 32'(DM_write), 32'd1);
    chk("rst_dm_addr", 32'(DM_address), 32'd0);
    chk("rst_dm_in", DM_in, 32'd0);

    // Word load
    preload(16'd4, 32'hDEADBEEF);
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 1'b1);
    wait_done("lw");
    chk("lw_rd_addr", 32'(last_rd_addr), 32'd4);

    // Sub-word loads and extension
    preload(16'd4, 32'h80FF0012);
    issue(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b0, 1'b1);
    issue(1'b0, F3_BU, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, 1'b0, 1'b1);
    issue(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1'b0, 1'b1);
    issue(1'b0, F3_HU, 32'h12, 32'h0, 32'h000080FF, 1'b0, 2, 1'b0, 1'b1);
    issue(1'b0, F3_B,  32'h10, 32'h0, 32'h00000012, 1'b0, 2, 1'b0, 1'b1);
    issue(1'b0, F3_H,  32'h10, 32'h0, 32'h00000012, 1'b0, 2, 1'b0, 1'b1);
    wait_done("subword_loads");

    // Read-modify-write stores
    preload(16'd4, 32'h11223344);
    wr0 = dm_wr_cnt;
    issue(1'b1, F3_B, 32'h11, 32'hFFFFFFAB, 32'h0, 1'b0, 3, 1'b0, 1'b1);
    wait_done("sb");
    chk("sb_write_cycles", 32'(dm_wr_cnt - wr0), 32'd1);
    chk("sb_dm_in", last_wr_data, 32'h1122AB44);
    chk("sb_wr_addr", 32'(last_wr_addr), 32'd4);
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'h1122AB44, 1'b0, 2, 1'b0, 1'b1);
    issue(1'b1, F3_H, 32'h12, 32'h12345566, 32'h0, 1'b0, 3, 1'b0, 1'b1);
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'h5566AB44, 1'b0, 2, 1'b0, 1'b1);
    issue(1'b1, F3_W, 32'h14, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b0, 1'b1);
    wait_done("sw");
    chk("sw_wr_addr", 32'(last_wr_addr), 32'd5);
    issue(1'b0, F3_W, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b0, 1'b1);
    wait_done("stores");

    // Errors: no DM access at all
    acc0 = dm_acc_cnt;
    issue(1'b1, F3_H,   32'h13,        32'hFFFF, 32'h0, 1'b1, 1, 1'b0, 1'b1);
    issue(1'b0, F3_W,   32'h2,         32'h0,    32'h0, 1'b1, 1, 1'b0, 1'b1);
    issue(1'b0, F3_W,   32'h0004_0000, 32'h0,    32'h0, 1'b1, 1, 1'b0, 1'b1);
    issue(1'b0, 3'b011, 32'h10,        32'h0,    32'h0, 1'b1, 1, 1'b0, 1'b1);
    issue(1'b1, F3_BU,  32'h10,        32'h0,    32'h0, 1'b1, 1, 1'b0, 1'b1);
    wait_done("errors");
    chk("err_no_dm_access", 32'(dm_acc_cnt - acc0), 32'd0);
    chk("err_mem_unchanged", mem[4], 32'h5566AB44);

    // Back-to-back with req_valid held high
    issue(1'b0, F3_W,  32'h10, 32'h0, 32'h5566AB44, 1'b0, 2, 1'b1, 1'b1);
    issue(1'b0, F3_BU, 32'h14, 32'h0, 32'h0000000D, 1'b0, 2, 1'b1, 1'b1);
    issue(1'b0, F3_H,  32'h16, 32'h0, 32'hFFFFCAFE, 1'b0, 2, 1'b0, 1'b1);
    wait_done("b2b");

    // Reset during the RD cycle of an SB
    preload(16'd6, 32'h01020304);
    wr0 = dm_wr_cnt;
    issue(1'b1, F3_B, 32'h18, 32'h000000EE, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("sb_rst_ready_low", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("sb_rst_idle_ready", 32'(bus.req_ready), 32'd1);

    // Reset during the access cycle of an SW
    issue(1'b1, F3_W, 32'h18, 32'hDEAD0000, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("sw_rst_idle_ready", 32'(bus.req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("rst_no_dm_write", 32'(dm_wr_cnt - wr0), 32'd0);
    chk("rst_mem_unchanged", mem[6], 32'h01020304);
    issue(1'b0, F3_W, 32'h18, 32'h0, 32'h01020304, 1'b0, 2, 1'b0, 1'b1);
    wait_done("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
